vga_image_window: RTL
=====================

# vga_image_window

Parametrised VGA display engine: generates 640x480-class timing from a pixel strobe and overlays one of NUM_IMG ROM-resident RGB565 images in a movable window on a programmable background colour. It replaces fixed-geometry image display in the media-player front panel. It sits between the clock divider (pix_en source) and the board VGA connector; image ROMs hang off its shared address bus.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48, horizontal porch/sync widths
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33, vertical porch/sync widths
- IMG_W, 300, image width in pixels; IMG_H, 200, image height in lines
- NUM_IMG, 3, number of image ROMs (1..8)
- ROM_LAT, 1, ROM read latency in pix_en ticks (1..3)
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pix_en  in  1  pixel strobe; all timing advances only when high
- sel  in  3  image select; values >= NUM_IMG show background only
- win_x  in  10  window left column; win_y  in  10  window top line
- bg_rgb  in  12  background colour {R,G,B}
- rom_addr  out  ADDR_W  shared address to all image ROMs
- rom_data  in  16*NUM_IMG  flattened RGB565 data, image k at [16k+15:16k]
- R, G, B  out  4 each  colour; zero outside active area
- h_sync, v_sync  out  1  active-low sync
- de  out  1  data-enable, high on visible pixels
- frame_start  out  1  one-tick pulse at first visible pixel of each frame

## Operation
- h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of horizontal params); wraps to 0 and advances v_cnt, which wraps at V_TOTAL-1.
- Counter 0 is the first visible pixel; h_sync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v_sync likewise on v_cnt.
- win_x/win_y (and sel, see Configuration) are captured at h_cnt=0, v_cnt=0.
- in_win = visible and h_cnt in [win_x, win_x+IMG_W) and v_cnt in [win_y, win_y+IMG_H), computed in 11-bit arithmetic so window edges beyond the screen clip, not wrap.
- Address generated incrementally, no multiplier: row_base resets to 0 at frame start and adds IMG_W after each window line; col counts 0..IMG_W-1 within the line; rom_addr = row_base + col. Clipped columns still advance row_base by IMG_W.
- Outside window rom_addr holds its last value.
- Pixel mux: in_win and sel < NUM_IMG -> R=d[15:12], G=d[10:7], B=d[4:1] of selected image; visible otherwise -> bg_rgb; blanking -> 0.

## Timing
- Stage 0 counters; stage 1 registered rom_addr, in_win, sync, de; ROM_LAT-stage delay line on in_win/sync/de/sel; output register.
- Total counter-to-pin latency ROM_LAT+2 ticks, identical for colour, h_sync, v_sync, de, frame_start.
- Pipeline stages advance only on pix_en; outputs stable between strobes.
- Reset: counters 0, row_base/col 0, rom_addr 0, R/G/B 0, de 0, h_sync 1, v_sync 1, frame_start 0, delay lines cleared.
- Reset mid-frame restarts at pixel (0,0); first frame_start ROM_LAT+2 ticks after first pix_en following release.
- win/sel changes mid-frame take effect only at next frame start.

## Configuration
- VGA_BORDER_EN defined: the outermost pixel ring of the window (col 0, col IMG_W-1, first and last window line) is forced to ~bg_rgb; ROM data ignored there.
- Undefined: no border logic; all window pixels come from ROM.

## Structure
- Package vga_pkg: default 640x480 timing constants, RGB565-to-444 field positions, rgb444 typedef.
- Sub-module vga_timing_gen: counters, sync, de, frame_start; reusable by other display blocks.

## Test plan
- Defaults, pix_en every 4th clk, one frame -> h_sync period 800 strobes low 96, v_sync low 2 lines of 525, de high 640x480.
- win_x=0, win_y=0, sel=0, ROM returns address as data -> pixel (0,0) shows data for addr 0, pixel (299,199) addr 59999, (300,0) shows bg_rgb.
- win_x=500, win_y=400 -> columns 500..639 drawn, row 1 of window starts at addr 300 (clip keeps stride).
- sel=5 with NUM_IMG=3 -> whole frame bg_rgb=12'h0F0 in visible area, 0 in blanking.
- sel and win_x changed at line 100 -> current frame unchanged, new values from next frame_start.
- rst low at line 240 for 3 clks -> outputs at reset values, timing restarts at (0,0); ROM_LAT=3 build shows latency 5 on all outputs.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour field positions and pipeline bundle types.
// Defaults describe standard 640x480 timing with an RGB565 image source.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int CNT_W = 11;

  localparam int R_HI = 15;
  localparam int R_LO = 12;
  localparam int G_HI = 10;
  localparam int G_LO = 7;
  localparam int B_HI = 4;
  localparam int B_LO = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic       in_win;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
`ifdef VGA_BORDER_EN
    logic       brd;
`endif
    logic [2:0] sel;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_IDLE = '{
    hs: 1'b1,
    vs: 1'b1,
    default: '0
  };

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with sync, data-enable and frame-start decode.
// All outputs except the counters are combinational from the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             visible,
  output logic             hs,
  output logic             vs,
  output logic             fs,
  output logic             line_last,
  output logic             frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int VS_BEG  = V_ACTIVE + V_FP;

  assign line_last  = h_cnt == CNT_W'(H_TOTAL - 1);
  assign frame_last = line_last && v_cnt == CNT_W'(V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_last) begin
        h_cnt <= '0;
        v_cnt <= frame_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign visible = h_cnt < CNT_W'(H_ACTIVE)
                && v_cnt < CNT_W'(V_ACTIVE);

  assign hs = !(h_cnt >= CNT_W'(HS_BEG)
             && h_cnt < CNT_W'(HS_BEG + H_SYNC));
  assign vs = !(v_cnt >= CNT_W'(VS_BEG)
             && v_cnt < CNT_W'(VS_BEG + V_SYNC));

  assign fs = h_cnt == '0 && v_cnt == '0;

endmodule

// File: rtl/vga_image_window.sv
// VGA engine overlaying one of NUM_IMG ROM images in a movable window.
// Define VGA_BORDER_EN to draw a ~bg_rgb ring around the window.
module vga_image_window
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int IMG_W    = 300,
  parameter int IMG_H    = 200,
  parameter int NUM_IMG  = 3,
  parameter int ROM_LAT  = 1,
  parameter int ADDR_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [2:0]             sel,
  input  logic [9:0]             win_x,
  input  logic [9:0]             win_y,
  input  logic [11:0]            bg_rgb,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [16*NUM_IMG-1:0]  rom_data,
  output logic [3:0]             R,
  output logic [3:0]             G,
  output logic [3:0]             B,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   de,
  output logic                   frame_start
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             vis;
  logic             hs0;
  logic             vs0;
  logic             fs0;
  logic             line_last;
  logic             frame_last;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .visible    (vis),
    .hs         (hs0),
    .vs         (vs0),
    .fs         (fs0),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  logic [9:0]       wx_q;
  logic [9:0]       wy_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] wx;
  logic [CNT_W-1:0] wy;
  logic [2:0]       sel_e;

  // Pixel (0,0) already uses the live inputs it is capturing.
  assign wx    = CNT_W'(fs0 ? win_x : wx_q);
  assign wy    = CNT_W'(fs0 ? win_y : wy_q);
  assign sel_e = fs0 ? sel : sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wx_q  <= '0;
      wy_q  <= '0;
      sel_q <= '0;
    end else if (pix_en && fs0) begin
      wx_q  <= win_x;
      wy_q  <= win_y;
      sel_q <= sel;
    end
  end

  logic h_in;
  logic v_line;
  logic in_win0;

  assign h_in    = h_cnt >= wx
                && h_cnt < wx + CNT_W'(IMG_W);
  assign v_line  = v_cnt >= wy
                && v_cnt < wy + CNT_W'(IMG_H)
                && v_cnt < CNT_W'(V_ACTIVE);
  assign in_win0 = vis && h_in && v_line;

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;

  // Stride is added per window line even when columns were clipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base <= '0;
      col      <= '0;
    end else if (pix_en) begin
      if (line_last) begin
        col <= '0;
        if (frame_last)
          row_base <= '0;
        else if (v_line)
          row_base <= row_base + ADDR_W'(IMG_W);
      end else if (in_win0) begin
        col <= col + ADDR_W'(1);
      end
    end
  end

  pix_ctl_t ctl0;
  pix_ctl_t ctl1;
  pix_ctl_t dly [ROM_LAT];

  always_comb begin
    ctl0        = CTL_IDLE;
    ctl0.in_win = in_win0;
    ctl0.de     = vis;
    ctl0.hs     = hs0;
    ctl0.vs     = vs0;
    ctl0.fs     = fs0;
    ctl0.sel    = sel_e;
`ifdef VGA_BORDER_EN
    ctl0.brd    = in_win0
               && (col == '0
                || col == ADDR_W'(IMG_W - 1)
                || row_base == '0
                || v_cnt == wy + CNT_W'(IMG_H - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      ctl1     <= CTL_IDLE;
      for (int i = 0; i < ROM_LAT; i++)
        dly[i] <= CTL_IDLE;
    end else if (pix_en) begin
      if (in_win0)
        rom_addr <= row_base + col;
      ctl1   <= ctl0;
      dly[0] <= ctl1;
      for (int i = 1; i < ROM_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  pix_ctl_t    ctl_o;
  logic [15:0] word;
  rgb444_t     pix;
  logic        unused_bits;

  assign ctl_o       = dly[ROM_LAT-1];
  assign unused_bits = ^{word[11], word[6:5], word[0]};

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IMG; k++)
      if (ctl_o.sel == 3'(k))
        word = rom_data[16*k +: 16];
    pix = '0;
    if (ctl_o.in_win && int'(ctl_o.sel) < NUM_IMG) begin
      pix.r = word[R_HI:R_LO];
      pix.g = word[G_HI:G_LO];
      pix.b = word[B_HI:B_LO];
    end else if (ctl_o.de) begin
      pix = rgb444_t'(bg_rgb);
    end
`ifdef VGA_BORDER_EN
    if (ctl_o.brd)
      pix = rgb444_t'(~bg_rgb);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {R, G, B}   <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      {R, G, B}   <= pix;
      h_sync      <= ctl_o.hs;
      v_sync      <= ctl_o.vs;
      de          <= ctl_o.de;
      frame_start <= ctl_o.fs;
    end
  end

endmodule
